// File: rtl/ag_ctrl_pkg.sv
// Shared state encoding and default timing constants for the hysteresis actuator controller.
package ag_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_OFF     = 2'd0,
      ST_MIN_ON  = 2'd1,
      ST_ON      = 2'd2,
      ST_MIN_OFF = 2'd3
   } ch_state_e;

   localparam int unsigned DEF_NUM_CH      = 4;
   localparam int unsigned DEF_SENSOR_W    = 8;
   localparam int unsigned DEF_TIMER_W     = 24;
   localparam int unsigned DEF_MIN_ON_CYC  = 250000;
   localparam int unsigned DEF_MIN_OFF_CYC = 250000;
   localparam int unsigned DEF_MAX_ON_CYC  = 15000000;

endpackage

// File: rtl/ag_channel_fsm.sv
// One actuator channel: demand compare, anti-short-cycle FSM, min/max timers and max-on fault.
// PFC_FAULT_STICKY_EN: fault stays latched until a fault_clr pulse while no switch-on demand.
module ag_channel_fsm
   import ag_ctrl_pkg::*;
#(
   parameter int unsigned SENSOR_W    = DEF_SENSOR_W,
   parameter int unsigned TIMER_W     = DEF_TIMER_W,
   parameter int unsigned MIN_ON_CYC  = DEF_MIN_ON_CYC,
   parameter int unsigned MIN_OFF_CYC = DEF_MIN_OFF_CYC,
   parameter int unsigned MAX_ON_CYC  = DEF_MAX_ON_CYC
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_ena,
   input  logic [SENSOR_W-1:0] i_sample,
   input  logic [SENSOR_W-1:0] i_thr_on,
   input  logic [SENSOR_W-1:0] i_thr_off,
   input  logic                i_dir,
   input  logic                i_ch_en,
   input  logic                i_ovr,
   input  logic                i_fault_clr,
   output logic                o_act,
   output logic [1:0]          o_state,
   output logic                o_fault,
   output logic                o_cfg_err
);

   localparam logic [TIMER_W-1:0] TMR_MAX      = '1;
   localparam logic [TIMER_W-1:0] MIN_ON_LAST  = TIMER_W'(MIN_ON_CYC - 1);
   localparam logic [TIMER_W-1:0] MIN_OFF_LAST = TIMER_W'(MIN_OFF_CYC - 1);
   localparam logic [TIMER_W-1:0] MAX_ON_T     = TIMER_W'(MAX_ON_CYC);

   ch_state_e          r_state, w_state_nxt;
   logic [TIMER_W-1:0] r_timer, w_timer_nxt, w_timer_inc;
   logic [TIMER_W-1:0] r_on_cnt, w_on_cnt_nxt, w_on_inc;
   logic               r_fault, w_fault_nxt;
   logic               r_cfg_err, w_cfg_err_nxt;
   logic               r_act, w_act_nxt;
   logic               w_on_req, w_off_req, w_force_off, w_allowed, w_max_hit, w_clr_ok;

   // Demand decode; direction selects which side of the band asks for actuation.
   always_comb begin
      if (i_dir) begin
         w_on_req      = (i_sample <= i_thr_on);
         w_off_req     = (i_sample >= i_thr_off);
         w_cfg_err_nxt = !(i_thr_on < i_thr_off);
      end else begin
         w_on_req      = (i_sample >= i_thr_on);
         w_off_req     = (i_sample <= i_thr_off);
         w_cfg_err_nxt = !(i_thr_on > i_thr_off);
      end
   end

   assign w_timer_inc = (r_timer == TMR_MAX) ? r_timer : r_timer + TIMER_W'(1);
   assign w_on_inc    = (r_on_cnt == TMR_MAX) ? r_on_cnt : r_on_cnt + TIMER_W'(1);
   assign w_force_off = !i_ch_en || i_ovr || r_cfg_err;
   assign w_allowed   = !w_force_off && !r_fault;

`ifdef PFC_FAULT_STICKY_EN
   assign w_clr_ok = i_fault_clr;
`else
   logic w_unused_fault_clr;
   assign w_unused_fault_clr = i_fault_clr;
   assign w_clr_ok = 1'b1;
`endif

   always_comb begin
      w_state_nxt  = r_state;
      w_timer_nxt  = r_timer;
      w_on_cnt_nxt = r_on_cnt;
      w_fault_nxt  = r_fault;
      w_max_hit    = 1'b0;
      case (r_state)
         ST_OFF: begin
            if (w_on_req && w_allowed) begin
               w_state_nxt  = ST_MIN_ON;
               w_timer_nxt  = '0;
               w_on_cnt_nxt = '0;
            end
         end
         ST_MIN_ON, ST_ON: begin
            w_on_cnt_nxt = w_on_inc;
            w_max_hit    = (w_on_inc >= MAX_ON_T);
            if (r_state == ST_MIN_ON) w_timer_nxt = w_timer_inc;
            // Force-off and max-on pre-empt the minimum on time; off demand only counts in ON.
            if (w_max_hit || w_force_off || ((r_state == ST_ON) && w_off_req)) begin
               w_state_nxt  = ST_MIN_OFF;
               w_timer_nxt  = '0;
               w_on_cnt_nxt = '0;
            end else if ((r_state == ST_MIN_ON) && (r_timer == MIN_ON_LAST)) begin
               w_state_nxt = ST_ON;
            end
         end
         ST_MIN_OFF: begin
            w_timer_nxt = w_timer_inc;
            if (r_timer == MIN_OFF_LAST) w_state_nxt = ST_OFF;
         end
         default: w_state_nxt = ST_OFF;
      endcase
      if (w_max_hit) w_fault_nxt = 1'b1;
      else if (r_fault && !w_on_req && w_clr_ok) w_fault_nxt = 1'b0;
      w_act_nxt = (w_state_nxt == ST_MIN_ON) || (w_state_nxt == ST_ON);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_OFF;
         r_timer   <= '0;
         r_on_cnt  <= '0;
         r_fault   <= 1'b0;
         r_cfg_err <= 1'b0;
         r_act     <= 1'b0;
      end else if (i_ena) begin
         r_state   <= w_state_nxt;
         r_timer   <= w_timer_nxt;
         r_on_cnt  <= w_on_cnt_nxt;
         r_fault   <= w_fault_nxt;
         r_cfg_err <= w_cfg_err_nxt;
         r_act     <= w_act_nxt;
      end
   end

   assign o_act     = r_act;
   assign o_state   = r_state;
   assign o_fault   = r_fault;
   assign o_cfg_err = r_cfg_err;

endmodule

// File: rtl/ag_hysteresis_ctrl.sv
// N-channel hysteresis actuator controller: sample capture, override register, per-channel FSMs.
// PFC_FAULT_STICKY_EN selects latched max-on faults cleared by fault_clr.
module ag_hysteresis_ctrl
   import ag_ctrl_pkg::*;
#(
   parameter int unsigned NUM_CH      = DEF_NUM_CH,
   parameter int unsigned SENSOR_W    = DEF_SENSOR_W,
   parameter int unsigned TIMER_W     = DEF_TIMER_W,
   parameter int unsigned MIN_ON_CYC  = DEF_MIN_ON_CYC,
   parameter int unsigned MIN_OFF_CYC = DEF_MIN_OFF_CYC,
   parameter int unsigned MAX_ON_CYC  = DEF_MAX_ON_CYC
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         ena,
   input  logic [NUM_CH*SENSOR_W-1:0]   sensor_in,
   input  logic                         sensor_valid,
   input  logic [NUM_CH*SENSOR_W-1:0]   thr_on,
   input  logic [NUM_CH*SENSOR_W-1:0]   thr_off,
   input  logic [NUM_CH-1:0]            dir,
   input  logic [NUM_CH-1:0]            ch_enable,
   input  logic                         cmd_override,
   input  logic                         fault_clr,
   output logic [NUM_CH-1:0]            actuator_out,
   output logic [2*NUM_CH-1:0]          ch_state,
   output logic [NUM_CH-1:0]            fault,
   output logic [NUM_CH-1:0]            cfg_err,
   output logic                         fault_any
);

   logic [NUM_CH*SENSOR_W-1:0] r_sample;
   logic                       r_ovr;

   // Sample hold and one-cycle override register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sample <= '0;
         r_ovr    <= 1'b0;
      end else if (ena) begin
         if (sensor_valid) r_sample <= sensor_in;
         r_ovr <= cmd_override;
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      ag_channel_fsm #(
         .SENSOR_W   (SENSOR_W),
         .TIMER_W    (TIMER_W),
         .MIN_ON_CYC (MIN_ON_CYC),
         .MIN_OFF_CYC(MIN_OFF_CYC),
         .MAX_ON_CYC (MAX_ON_CYC)
      ) u_ch (
         .clk        (clk),
         .rst_n      (rst_n),
         .i_ena      (ena),
         .i_sample   (r_sample[i*SENSOR_W +: SENSOR_W]),
         .i_thr_on   (thr_on[i*SENSOR_W +: SENSOR_W]),
         .i_thr_off  (thr_off[i*SENSOR_W +: SENSOR_W]),
         .i_dir      (dir[i]),
         .i_ch_en    (ch_enable[i]),
         .i_ovr      (r_ovr),
         .i_fault_clr(fault_clr),
         .o_act      (actuator_out[i]),
         .o_state    (ch_state[2*i +: 2]),
         .o_fault    (fault[i]),
         .o_cfg_err  (cfg_err[i])
      );
   end

   assign fault_any = |(fault | cfg_err);

endmodule

// File: tb/tb_ag_hysteresis_ctrl.sv
// Bench for ag_hysteresis_ctrl: elapsed-time reference model checked every cycle, directed and random stimulus.
module tb_ag_hysteresis_ctrl;

   localparam int NCH = 2, SW = 8, TW = 24, MON = 4, MOFF = 3, MAXON = 20;

   logic                clk = 1'b0;
   logic                rst_n, ena, sensor_valid, cmd_override, fault_clr;
   logic [NCH*SW-1:0]   sensor_in, thr_on, thr_off;
   logic [NCH-1:0]      dir, ch_enable, actuator_out, fault, cfg_err;
   logic [2*NCH-1:0]    ch_state;
   logic                fault_any;
   int                  checks = 0, errors = 0;
   bit                  chk_on = 1'b0;

   always #5 clk = ~clk;

   ag_hysteresis_ctrl #(.NUM_CH(NCH), .SENSOR_W(SW), .TIMER_W(TW),
      .MIN_ON_CYC(MON), .MIN_OFF_CYC(MOFF), .MAX_ON_CYC(MAXON)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .sensor_in(sensor_in), .sensor_valid(sensor_valid),
      .thr_on(thr_on), .thr_off(thr_off), .dir(dir), .ch_enable(ch_enable),
      .cmd_override(cmd_override), .fault_clr(fault_clr), .actuator_out(actuator_out),
      .ch_state(ch_state), .fault(fault), .cfg_err(cfg_err), .fault_any(fault_any));

   // Reference model: on/off flag plus cycles elapsed since the last switch and on-duration.
   int m_sample[NCH], m_el[NCH], m_dur[NCH];
   bit m_on[NCH], m_fault[NCH], m_cfg[NCH], m_ovr;

   function automatic int fld(logic [NCH*SW-1:0] v, int c);
      return int'(v[c*SW +: SW]);
   endfunction

   function automatic int mstate(int c);
      if (m_on[c]) return (m_el[c] < MON) ? 1 : 2;
      return (m_el[c] < MOFF) ? 3 : 0;
   endfunction

   task automatic model_reset();
      for (int c = 0; c < NCH; c++) begin
         m_sample[c] = 0; m_el[c] = MOFF; m_dur[c] = 0;
         m_on[c] = 0; m_fault[c] = 0; m_cfg[c] = 0;
      end
      m_ovr = 0;
   endtask

   task automatic model_step();
      for (int c = 0; c < NCH; c++) begin
         int s, ton, toff;
         bit onr, offr, frc, hit, clr_ok;
         s = m_sample[c]; ton = fld(thr_on, c); toff = fld(thr_off, c);
         onr  = dir[c] ? (s <= ton) : (s >= ton);
         offr = dir[c] ? (s >= toff) : (s <= toff);
         frc  = !ch_enable[c] || m_ovr || m_cfg[c];
         hit  = 0;
`ifdef PFC_FAULT_STICKY_EN
         clr_ok = fault_clr;
`else
         clr_ok = 1;
`endif
         if (m_on[c]) begin
            hit = (m_dur[c] + 1 >= MAXON);
            if (hit || frc || (m_el[c] >= MON && offr)) begin
               m_on[c] = 0; m_el[c] = 0; m_dur[c] = 0;
            end else begin
               if (m_el[c] < 1000) m_el[c]++;
               m_dur[c]++;
            end
         end else if (m_el[c] >= MOFF) begin
            if (onr && !frc && !m_fault[c]) begin
               m_on[c] = 1; m_el[c] = 0; m_dur[c] = 0;
            end
         end else begin
            m_el[c]++;
         end
         if (hit) m_fault[c] = 1;
         else if (m_fault[c] && !onr && clr_ok) m_fault[c] = 0;
         m_cfg[c] = dir[c] ? (ton >= toff) : (ton <= toff);
      end
      if (sensor_valid) for (int c = 0; c < NCH; c++) m_sample[c] = fld(sensor_in, c);
      m_ovr = cmd_override;
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) model_reset();
      else if (ena) model_step();
   end

   task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      logic [NCH-1:0]   ea, ef, ec;
      logic [2*NCH-1:0] es;
      if (chk_on) begin
         for (int c = 0; c < NCH; c++) begin
            ea[c] = m_on[c]; ef[c] = m_fault[c]; ec[c] = m_cfg[c];
            es[2*c +: 2] = 2'(mstate(c));
         end
         cmp("actuator_out", actuator_out, ea);
         cmp("ch_state", ch_state, es);
         cmp("fault", fault, ef);
         cmp("cfg_err", cfg_err, ec);
         cmp("fault_any", fault_any, |(ef | ec));
      end
   end

   task automatic drive_sample(int s0, int s1);
      sensor_in = {8'(s1), 8'(s0)};
      sensor_valid = 1'b1;
      @(negedge clk);
      sensor_valid = 1'b0;
   endtask

   task automatic wait_state(int c, int st, int budget);
      int n;
      n = 0;
      while (mstate(c) != st && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (mstate(c) != st) begin
         checks++; errors++;
         $display("FAIL wait_state ch%0d: still %0d, wanted %0d", c, mstate(c), st);
      end
   endtask

   initial begin
      rst_n = 1'b0; ena = 1'b1; sensor_valid = 1'b0; cmd_override = 1'b0; fault_clr = 1'b0;
      sensor_in = '0; dir = 2'b01; ch_enable = 2'b00;
      thr_on  = {8'd200, 8'd50};
      thr_off = {8'd150, 8'd80};
      model_reset();
      chk_on = 1'b1;
      @(negedge clk);
      cmp("reset_act", actuator_out, 0);
      cmp("reset_state", ch_state, 0);
      rst_n = 1'b1;
      drive_sample(60, 160);
      ch_enable = 2'b11;
      repeat (2) @(negedge clk);

      // Basic switch-on latency and hold inside the band
      drive_sample(40, 160);
      cmp("on_lat_1cyc", actuator_out[0], 0);
      @(negedge clk);
      cmp("on_lat_2cyc", actuator_out[0], 1);
      drive_sample(60, 160);
      repeat (6) @(negedge clk);
      cmp("hold_band", actuator_out[0], 1);
      drive_sample(90, 160);
      cmp("off_lat_1cyc", actuator_out[0], 1);
      @(negedge clk);
      cmp("off_lat_2cyc", actuator_out[0], 0);

      // Off request during MIN_ON is ignored
      wait_state(0, 0, 20);
      sensor_in = {8'd160, 8'd40}; sensor_valid = 1'b1;
      @(negedge clk);
      sensor_in = {8'd160, 8'd90};
      @(negedge clk);
      sensor_valid = 1'b0;
      for (int k = 0; k < MON; k++) begin
         cmp("min_on_hold", actuator_out[0], 1);
         @(negedge clk);
      end
      wait_state(0, 3, 20);
      drive_sample(40, 160);
      for (int k = 0; k < 3; k++) begin
         cmp("min_off_hold", actuator_out[0], 0);
         @(negedge clk);
      end
      cmp("re_on", actuator_out[0], 1);

      // Max-on fault on ch1 (cooler direction)
      drive_sample(60, 210);
      repeat (20) @(negedge clk);
      cmp("maxon_before", {fault[1], actuator_out[1]}, 2'b01);
      @(negedge clk);
      cmp("maxon_fault", {fault_any, fault[1], actuator_out[1]}, 3'b110);
      drive_sample(60, 160);
      @(negedge clk);
`ifdef PFC_FAULT_STICKY_EN
      cmp("fault_sticky", fault[1], 1);
      fault_clr = 1'b1;
      @(negedge clk);
      fault_clr = 1'b0;
`endif
      cmp("fault_cleared", fault[1], 0);

      // Equal thresholds: configuration error blocks actuation
      thr_on[7:0] = 8'd100; thr_off[7:0] = 8'd100;
      drive_sample(10, 160);
      @(negedge clk);
      cmp("cfg_err_set", cfg_err[0], 1);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         cmp("cfg_blocks", actuator_out[0], 0);
      end
      thr_on[7:0] = 8'd50; thr_off[7:0] = 8'd80;
      drive_sample(60, 160);
      repeat (3) @(negedge clk);

      // Global override while both channels are ON
      drive_sample(40, 210);
      wait_state(0, 2, 30);
      wait_state(1, 2, 30);
      cmd_override = 1'b1;
      @(negedge clk);
      cmd_override = 1'b0;
      cmp("ovr_1cyc", actuator_out, 2'b11);
      @(negedge clk);
      cmp("ovr_2cyc_act", actuator_out, 2'b00);
      cmp("ovr_2cyc_state", ch_state, 4'b1111);

      // Enable freeze in MIN_ON
      drive_sample(40, 160);
      wait_state(0, 1, 30);
      ena = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         cmp("ena_freeze", ch_state[1:0], 1);
      end
      ena = 1'b1;

      // Asynchronous reset while in MIN_ON
      drive_sample(90, 160);
      wait_state(0, 3, 40);
      wait_state(0, 0, 20);
      drive_sample(40, 160);
      wait_state(0, 1, 20);
      #2 rst_n = 1'b0;
      #1;
      cmp("async_rst_act", actuator_out, 0);
      cmp("async_rst_state", ch_state, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         if ($urandom_range(49) == 0) begin
            for (int c = 0; c < NCH; c++) begin
               int a, b;
               a = $urandom_range(220, 30);
               b = $urandom_range(30, 1);
               dir[c] = 1'($urandom_range(1));
               thr_on[c*SW +: SW] = 8'(a);
               if ($urandom_range(9) == 0) thr_off[c*SW +: SW] = 8'(a);
               else thr_off[c*SW +: SW] = dir[c] ? 8'(a + b) : 8'(a - b);
            end
         end
         sensor_valid = ($urandom_range(5) == 0);
         sensor_in    = NCH*SW'($urandom);
         cmd_override = ($urandom_range(39) == 0);
         ena          = ($urandom_range(19) != 0);
         fault_clr    = ($urandom_range(9) == 0);
         for (int c = 0; c < NCH; c++) ch_enable[c] = ($urandom_range(29) != 0);
      end
      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
